// File: rtl/lcd1602_pkg.sv
// Shared definitions for the LCD1602 write sequencer.
//   state_t      : sequencer FSM states
//   CMD_*        : HD44780 command bytes used by the init ROM
//   INIT_LEN     : number of init ROM entries
//   is_long_cmd  : true for commands that need the long execution wait
//   init_rom     : init ROM lookup by index
package lcd1602_pkg;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_INIT_SETUP,
        ST_INIT_EN,
        ST_INIT_HOLD,
        ST_INIT_WAIT,
        ST_IDLE,
        ST_SETUP,
        ST_EN,
        ST_HOLD,
        ST_WAIT
    } state_t;

    localparam logic [7:0] CMD_FUNCSET = 8'h38; // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISPON  = 8'h0C; // display on, cursor off
    localparam logic [7:0] CMD_ENTRY   = 8'h06; // increment, no shift
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;

    localparam int INIT_LEN = 4;

    // Clear (0x01) and home (0x02/0x03, bit 0 is don't-care) need the long wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == 8'h03));
    endfunction

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        logic [7:0] val;
        case (idx)
            2'd0:    val = CMD_FUNCSET;
            2'd1:    val = CMD_DISPON;
            2'd2:    val = CMD_ENTRY;
            default: val = CMD_CLEAR;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/lcd1602_phase_timer.sv
// Single down-counter used for every sequencer phase.
//   clk      : system clock
//   load     : load load_val this cycle (also used as the reset path)
//   load_val : phase length minus one
//   done     : counter has reached zero; it stays at zero (no wrap)
module lcd1602_phase_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // No separate reset: the sequencer asserts load during reset.
    always_ff @(posedge clk) begin
        if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/lcd1602_write_sequencer.sv
// Timing controller for an HD44780-style 16x2 LCD on an 8-bit write-only bus.
// Runs the power-up wait and fixed init sequence, then writes one byte per
// valid/ready handshake with setup, E pulse, hold and execution wait.
//   clk, reset          : system clock, synchronous active-high reset
//   req_valid/rs/data   : byte source (rs=0 command, rs=1 character data)
//   req_ready           : byte accepted on this cycle's edge when valid
//   init_done           : init sequence complete, sticky until reset
//   busy                : init or transfer in progress
//   lcd_rs/rw/en/dat    : LCD bus (rw tied low, en registered)
module lcd1602_write_sequencer
    import lcd1602_pkg::*;
#(
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 4,
    parameter int T_EN    = 25,
    parameter int T_HOLD  = 2,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000,
    parameter int CNT_W   = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_dat
);

    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR - 1);

    state_t           state;
    state_t           next_state;
    logic [1:0]       init_idx;
    logic             hold_rs;
    logic [7:0]       hold_data;

    logic             accept;
    logic             timer_done;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;

    logic             en_nxt;
    logic             rs_nxt;
    logic [7:0]       dat_nxt;
    logic             hold_rs_nxt;
    logic [7:0]       hold_data_nxt;
    logic [1:0]       idx_nxt;
    logic             done_nxt;

    assign lcd_rw = 1'b0;
    assign accept = req_valid && req_ready;

    lcd1602_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_PWRUP;
            lcd_en    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_dat   <= '0;
            hold_rs   <= 1'b0;
            hold_data <= '0;
            init_idx  <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= next_state;
            lcd_en    <= en_nxt;
            lcd_rs    <= rs_nxt;
            lcd_dat   <= dat_nxt;
            hold_rs   <= hold_rs_nxt;
            hold_data <= hold_data_nxt;
            init_idx  <= idx_nxt;
            init_done <= done_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_PWRUP:      if (timer_done) next_state = ST_INIT_SETUP;
            ST_INIT_SETUP: if (timer_done) next_state = ST_INIT_EN;
            ST_INIT_EN:    if (timer_done) next_state = ST_INIT_HOLD;
            ST_INIT_HOLD:  if (timer_done) next_state = ST_INIT_WAIT;
            ST_INIT_WAIT: begin
                if (timer_done) begin
                    next_state = (init_idx == 2'(INIT_LEN - 1)) ? ST_IDLE : ST_INIT_SETUP;
                end
            end
            ST_IDLE:       if (accept) next_state = ST_SETUP;
            ST_SETUP:      if (timer_done) next_state = ST_EN;
            ST_EN:         if (timer_done) next_state = ST_HOLD;
            ST_HOLD:       if (timer_done) next_state = ST_WAIT;
            ST_WAIT: begin
                // The last wait cycle already offers ready so back-to-back
                // bytes go straight to SETUP without an IDLE cycle.
                if (timer_done) next_state = accept ? ST_SETUP : ST_IDLE;
            end
            default:       next_state = ST_PWRUP;
        endcase
    end

    // Outputs, register next values and timer control.
    always_comb begin
        req_ready     = (state == ST_IDLE) || ((state == ST_WAIT) && timer_done);
        busy          = (state != ST_IDLE);

        en_nxt        = (next_state == ST_EN) || (next_state == ST_INIT_EN);
        rs_nxt        = lcd_rs;
        dat_nxt       = lcd_dat;
        hold_rs_nxt   = hold_rs;
        hold_data_nxt = hold_data;
        idx_nxt       = init_idx;
        done_nxt      = init_done;

        if ((next_state == ST_INIT_SETUP) && (state != ST_INIT_SETUP)) begin
            idx_nxt       = (state == ST_PWRUP) ? 2'd0 : (init_idx + 2'd1);
            rs_nxt        = 1'b0;
            dat_nxt       = init_rom(idx_nxt);
            hold_rs_nxt   = 1'b0;
            hold_data_nxt = dat_nxt;
        end

        if (accept) begin
            rs_nxt        = req_rs;
            dat_nxt       = req_data;
            hold_rs_nxt   = req_rs;
            hold_data_nxt = req_data;
        end

        if ((state == ST_INIT_WAIT) && (next_state == ST_IDLE)) begin
            done_nxt = 1'b1;
        end

        timer_load = reset || (next_state != state);
        timer_val  = LD_PWRUP;
        if (!reset) begin
            case (next_state)
                ST_INIT_SETUP, ST_SETUP: timer_val = LD_SETUP;
                ST_INIT_EN, ST_EN:       timer_val = LD_EN;
                ST_INIT_HOLD, ST_HOLD:   timer_val = LD_HOLD;
                ST_INIT_WAIT, ST_WAIT:   timer_val = is_long_cmd(hold_rs, hold_data) ? LD_CLR : LD_CMD;
                default:                 timer_val = LD_PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd1602_write_sequencer.sv
// Self-checking bench for lcd1602_write_sequencer with short sim timings.
// A scoreboard queue holds the expected {rs,data} of every E pulse; entries
// are pushed when init starts or a byte is accepted, popped on each E rise.
module tb_lcd1602_write_sequencer;

    localparam int T_PWRUP = 20;
    localparam int T_SETUP = 2;
    localparam int T_EN    = 3;
    localparam int T_HOLD  = 1;
    localparam int T_CMD   = 10;
    localparam int T_CLR   = 30;

    localparam int LAT_CMD = T_SETUP + T_EN + T_HOLD + T_CMD;
    localparam int LAT_CLR = T_SETUP + T_EN + T_HOLD + T_CLR;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_ready;
    logic       init_done;
    logic       busy;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_dat;

    always #5 clk = ~clk;

    lcd1602_write_sequencer #(
        .T_PWRUP (T_PWRUP),
        .T_SETUP (T_SETUP),
        .T_EN    (T_EN),
        .T_HOLD  (T_HOLD),
        .T_CMD   (T_CMD),
        .T_CLR   (T_CLR),
        .CNT_W   (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .req_ready (req_ready),
        .init_done (init_done),
        .busy      (busy),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_dat   (lcd_dat)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;   // number of rising edges so far

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // ---------------- scoreboard / E-pulse monitor ----------------
    logic [8:0] exp_q[$];
    logic       prev_en   = 1'b0;
    int         width     = 0;
    logic [8:0] pulse_bus = '0;
    int         fall_cyc  = 0;
    int         rise_cyc  = 0;
    int         pulses    = 0;

    always @(negedge clk) begin
        if (reset) begin
            prev_en = 1'b0;
            width   = 0;
        end else begin
            if (lcd_en && !prev_en) begin
                rise_cyc  = cyc;
                pulse_bus = {lcd_rs, lcd_dat};
                width     = 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pulse_unexpected: got rs=%0d dat=0x%0h, expected no pulse", lcd_rs, lcd_dat);
                end else begin
                    check("pulse_bus", {lcd_rs, lcd_dat}, exp_q.pop_front());
                end
            end else if (lcd_en) begin
                width++;
                check("bus_stable_in_e", {lcd_rs, lcd_dat}, pulse_bus);
            end
            if (!lcd_en && prev_en) begin
                check("e_width", width, T_EN);
                check("bus_hold_after_e", {lcd_rs, lcd_dat}, pulse_bus);
                fall_cyc = cyc;
                pulses++;
            end
            prev_en = lcd_en;
        end
    end

    // ---------------- acceptance monitor ----------------
    int acc_cnt  = 0;
    int last_acc = 0;

    always @(negedge clk) begin
        if (!reset && req_valid && req_ready) begin
            exp_q.push_back({req_rs, req_data});
            check("accept_after_init", init_done, 1);
            last_acc = cyc + 1;
            acc_cnt++;
        end
    end

    // ---------------- helpers ----------------
    task automatic release_reset();
        reset = 1'b0;
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    // Called at posedge+#1 right after the last reset edge.
    task automatic check_init();
        int   en_high = 0;
        int   p0      = pulses;
        bit   got     = 1'b0;
        logic prev_rdy;
        @(negedge clk);
        check("rst_lcd_en", lcd_en, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_dat", lcd_dat, 0);
        check("rst_lcd_rw", lcd_rw, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_init_done", init_done, 0);
        check("rst_busy", busy, 1);
        for (int i = 1; i < T_PWRUP; i++) begin
            @(negedge clk);
            if (lcd_en) en_high++;
        end
        check("pwrup_en_low", en_high, 0);
        prev_rdy = req_ready;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (init_done) begin
                got = 1'b1;
                break;
            end
            prev_rdy = req_ready;
        end
        check("init_done_seen", got, 1);
        check("ready_before_init_done", prev_rdy, 0);
        check("ready_with_init_done", req_ready, 1);
        check("init_busy_clear", busy, 0);
        check("init_pulse_count", pulses - p0, 4);
        check("clear_gap", cyc - fall_cyc, T_HOLD + T_CLR);
        check("init_queue_empty", exp_q.size(), 0);
    endtask

    task automatic send(input logic rs, input logic [7:0] d, output int k, output bit ok);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        k = cyc + 1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_rs    = ~rs;   // later input changes must not reach the bus
        req_data  = ~d;
    endtask

    task automatic wait_pulses(input int target, input string name);
        bit got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pulses >= target) begin
                got = 1'b1;
                break;
            end
        end
        check(name, got, 1);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         latency;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        int   k1;
        int   k2;
        int   ret;
        int   rise;
        int   a0;
        int   p0;
        bit   ok;
        bit   got;

        vecs[0] = '{rs: 1'b1, data: 8'h41, latency: LAT_CMD}; // 'A'
        vecs[1] = '{rs: 1'b0, data: 8'h01, latency: LAT_CLR}; // clear
        vecs[2] = '{rs: 1'b0, data: 8'h80, latency: LAT_CMD}; // set DDRAM addr
        vecs[3] = '{rs: 1'b0, data: 8'h02, latency: LAT_CLR}; // home
        vecs[4] = '{rs: 1'b0, data: 8'h03, latency: LAT_CLR}; // home, bit0 set
        vecs[5] = '{rs: 1'b1, data: 8'h01, latency: LAT_CMD}; // data 0x01 is not clear
        vecs[6] = '{rs: 1'b0, data: 8'h04, latency: LAT_CMD}; // just above home range

        // 1: reset and init sequence
        reset     = 1'b1;
        req_valid = 1'b0;
        req_rs    = 1'b0;
        req_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        release_reset();
        check_init();

        // 2/4: single transfers, table driven
        foreach (vecs[i]) begin
            send(vecs[i].rs, vecs[i].data, k, ok);
            check($sformatf("accept_%0d", i), ok, 1);
            @(negedge clk);
            check($sformatf("busy_after_accept_%0d", i), busy, 1);
            check($sformatf("ready_low_after_accept_%0d", i), req_ready, 0);
            @(negedge clk);
            check($sformatf("bus_%0d", i), {lcd_rs, lcd_dat}, {vecs[i].rs, vecs[i].data});
            rise = -1;
            got  = 1'b0;
            for (int j = 0; j < 200; j++) begin
                @(negedge clk);
                if (lcd_en && rise < 0) rise = cyc;
                if (req_ready) begin
                    got = 1'b1;
                    break;
                end
            end
            ret = cyc + 1;
            check($sformatf("ready_seen_%0d", i), got, 1);
            check($sformatf("e_rise_offset_%0d", i), rise - k, T_SETUP);
            check($sformatf("ready_return_%0d", i), ret - k, vecs[i].latency);
        end

        // 3: req_valid held high across two bytes
        a0 = acc_cnt;
        p0 = pulses;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h48;
        ok = 1'b0;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        k1 = cyc + 1;
        @(posedge clk);
        #1;
        req_data = 8'h69;
        got = 1'b0;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        k2 = cyc + 1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data  = 8'hEE;
        check("b2b_first_accept", ok, 1);
        check("b2b_second_accept", got, 1);
        check("b2b_cadence", k2 - k1, LAT_CMD);
        wait_pulses(p0 + 2, "b2b_pulses_seen");
        check("b2b_accept_count", acc_cnt - a0, 2);
        check("b2b_queue_empty", exp_q.size(), 0);

        // 6: reset during the second cycle of an E pulse
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h55;
        ok = 1'b0;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("mid_e_accept", ok, 1);
        got = 1'b0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            if (lcd_en) begin
                got = 1'b1;
                break;
            end
        end
        check("mid_e_pulse_seen", got, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_e_en_before_reset_edge", lcd_en, 1);
        @(negedge clk);
        check("mid_e_en_dropped", lcd_en, 0);
        check("mid_e_init_done", init_done, 0);
        check("mid_e_ready", req_ready, 0);
        check("mid_e_busy", busy, 1);

        // 5: request held during power-up/init, accepted once after init
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h7E;
        a0 = acc_cnt;
        @(posedge clk);
        #1;
        release_reset();
        check_init();
        check("early_req_not_accepted", acc_cnt - a0, 0);
        p0 = pulses;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("early_req_accepted_once", acc_cnt - a0, 1);
        wait_pulses(p0 + 1, "early_req_pulse_seen");
        check("early_req_queue_empty", exp_q.size(), 0);
        repeat (LAT_CMD + 4) @(negedge clk);
        check("final_idle_ready", req_ready, 1);
        check("final_pulse_count", pulses - p0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd1602_write_sequencer.md
Name: lcd1602_write_sequencer

Overview:
- Timing controller between a character/command source and the 16x2 HD44780-style LCD (8-bit bus, write-only).
- Runs the power-up wait and the fixed init sequence.
- Then accepts one byte per valid/ready handshake and generates compliant RS/DAT setup, E pulse, hold and per-command execution waits from the system clock.
- Replaces the free-running divided-clock approach; all logic runs on clk.

Parameters:
- T_PWRUP, 750000: cycles after reset before the first init write (15 ms at 50 MHz).
- T_SETUP, 4: cycles RS/DAT are stable with E low before the E rise.
- T_EN, 25: cycles E is held high.
- T_HOLD, 2: cycles RS/DAT are held after the E fall.
- T_CMD, 2000: execution wait for normal commands and data (40 us).
- T_CLR, 82000: execution wait for clear (0x01) and home (0x02/0x03) with rs=0 (1.64 ms).
- CNT_W, 20: timer width. All T_* parameters must be >=1 and <2^CNT_W.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  source has a byte
- req_rs  in  1  0 = command, 1 = character data
- req_data  in  8  byte to write
- req_ready  out  1  sequencer accepts a byte this cycle
- init_done  out  1  init sequence complete, sticky until reset
- busy  out  1  transfer or init in progress
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  tied 0
- lcd_en  out  1  LCD enable strobe
- lcd_dat  out  8  LCD data bus

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset wins over every other event.
- Values during and after reset: lcd_en=0, lcd_rs=0, lcd_dat=0x00, lcd_rw=0, req_ready=0, init_done=0, busy=1, state=PWRUP, timer loaded with T_PWRUP.
- State machine: PWRUP, INIT_SETUP, INIT_EN, INIT_HOLD, INIT_WAIT, IDLE, SETUP, EN, HOLD, WAIT.
- PWRUP:
  - Counts T_PWRUP cycles, then goes to INIT_SETUP with init index 0.
- Init ROM, all rs=0, in order:
  - 0x38 (8-bit, 2 lines, 5x8)
  - 0x0C (display on, cursor off)
  - 0x06 (increment, no shift)
  - 0x01 (clear)
- INIT_* timing:
  - Identical to the write phases below.
  - Wait length follows the same clear/home rule, so 0x01 uses T_CLR.
  - After the wait for index 3: init_done=1, go to IDLE.
- IDLE:
  - req_ready=1, busy=0.
  - lcd_en=0; lcd_rs/lcd_dat keep the last driven values.
- Accept:
  - Occurs when req_valid && req_ready at edge k.
  - req_rs/req_data are captured into a holding register; later input changes are ignored.
  - req_ready=0 and busy=1 from edge k onward; go to SETUP.
- Write phases:
  - SETUP: lcd_rs/lcd_dat driven from the holding register, lcd_en=0, for T_SETUP cycles.
  - EN: lcd_en=1 for exactly T_EN cycles.
  - HOLD: lcd_en=0, bus unchanged, for T_HOLD cycles.
  - WAIT: T_CLR if rs=0 and data is 0x01, 0x02 or 0x03; otherwise T_CMD.
- Latency: req_ready reasserts at edge k + T_SETUP + T_EN + T_HOLD + Twait, with no extra idle cycle. Back-to-back requests are therefore accepted at that cadence.
- Before init: req_ready=0 until init_done. Requests asserted earlier are held off, not dropped; the source keeps req_valid.
- lcd_en registered: lcd_en comes straight from a flop, so no glitches, and it is never high outside EN/INIT_EN.
- Reset mid-operation, including mid-E-pulse: lcd_en drops at the reset edge and the full power-up and init sequence restarts.
- Timer behaviour:
  - Single down-counter, loaded with (T-1) on phase entry.
  - The phase ends when count==0 is observed.
  - No wrap: the counter stops at 0.
- req_valid with req_ready=0 has no effect.

Decomposition:
- Shared package lcd1602_pkg:
  - state enum.
  - Init ROM constants: CMD_FUNCSET=0x38, CMD_DISPON=0x0C, CMD_ENTRY=0x06, CMD_CLEAR=0x01, CMD_HOME=0x02.
  - INIT_LEN=4.
  - is_long_cmd(rs,data) function.
- Sub-module lcd1602_phase_timer:
  - Inputs: load, load_val[CNT_W].
  - Output: done.
  - Instantiated once; the FSM owns all phase sequencing.

Test Plan:
All scenarios use sim parameters T_PWRUP=20, T_SETUP=2, T_EN=3, T_HOLD=1, T_CMD=10, T_CLR=30.
1. Reset 3 cycles, release -> lcd_en stays 0 for 20 cycles. Four E pulses follow, each 3 cycles wide, carrying 0x38, 0x0C, 0x06, 0x01 with rs=0. Gap after 0x01 is 30 cycles. init_done and req_ready rise together.
2. After init, req_rs=1, req_data=0x41 ('A') accepted at edge k -> lcd_rs=1 and lcd_dat=0x41 from k+1. lcd_en high for cycles k+2..k+4. req_ready returns at k+16.
3. req_valid held high with data 0x48, 0x69 (two bytes) -> exactly two E pulses in order. Second acceptance exactly 16 cycles after the first. Input changes during a transfer do not alter lcd_dat.
4. Command rs=0, 0x01 -> wait phase 30 cycles; req_ready returns at k+36. Command rs=0, 0x80 -> returns at k+16.
5. req_valid asserted during init -> not accepted until init_done. Byte then written once.
6. Reset asserted during the second cycle of an E pulse -> lcd_en=0 at that edge, init_done=0, full 20-cycle power-up and init replay.
